// File: rtl/id_decode_stage_pkg.sv
// Shared ISA constants, default field widths and opcode classification for the decode stage.
// No logic or latency of its own.
// No flow control of its own.
package id_decode_stage_pkg;

  // Default instruction layout: opcode | r_i | r_j | r_k | imme, packed from the MSB down.
  localparam int INSTR_SIZE_DEF = 32;
  localparam int CODE_SIZE_DEF  = 6;
  localparam int REG_SIZE_DEF   = 5;
  localparam int IMME_SIZE_DEF  = 11;
  localparam int DATA_SIZE_DEF  = 32;
  localparam int SIGN_EXT_DEF   = 1;
  localparam int HCNT_SIZE_DEF  = 16;

  // Memory opcodes and the ALU function they always use for address generation.
  localparam int LW_CODE_DEF  = 2;
  localparam int SW_CODE_DEF  = 3;
  localparam int ADD_FUNC_DEF = 1;

  // Opcode class flags carried along with every decoded instruction.
  typedef struct packed {
    logic is_load;
    logic is_store;
  } op_flags_t;

  // Classify an opcode against the configured load/store codes.
  function automatic op_flags_t classify_op(input logic [31:0] code,
                                            input logic [31:0] lw_code,
                                            input logic [31:0] sw_code);
    op_flags_t f;
    f.is_load  = (code == lw_code);
    f.is_store = (code == sw_code);
    return f;
  endfunction

endpackage

// File: rtl/id_decode_stage_instr_field_decode.sv
// Splits an instruction word into fields, overrides the function for loads/stores, extends the immediate.
// Purely combinational, zero latency.
// No flow control; the caller decides when the result is used.
module instr_field_decode
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_SIZE = INSTR_SIZE_DEF,
  parameter int CODE_SIZE  = CODE_SIZE_DEF,
  parameter int REG_SIZE   = REG_SIZE_DEF,
  parameter int IMME_SIZE  = IMME_SIZE_DEF,
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int SIGN_EXT   = SIGN_EXT_DEF,
  parameter int LW_CODE    = LW_CODE_DEF,
  parameter int SW_CODE    = SW_CODE_DEF,
  parameter int ADD_FUNC   = ADD_FUNC_DEF
) (
  input  logic [INSTR_SIZE-1:0] instr,
  output logic [CODE_SIZE-1:0]  code,
  output logic [REG_SIZE-1:0]   r_i,
  output logic [REG_SIZE-1:0]   r_j,
  output logic [REG_SIZE-1:0]   r_k,
  output logic [IMME_SIZE-1:0]  imme,
  output logic [DATA_SIZE-1:0]  imme_ext,
  output logic [IMME_SIZE-1:0]  i_func,
  output op_flags_t             flags
);

  // Bit positions of each field, walking down from the MSB.
  localparam int CODE_LSB = INSTR_SIZE - CODE_SIZE;
  localparam int RI_LSB   = CODE_LSB - REG_SIZE;
  localparam int RJ_LSB   = RI_LSB - REG_SIZE;
  localparam int RK_LSB   = RJ_LSB - REG_SIZE;
  localparam int IM_LSB   = RK_LSB - IMME_SIZE;

  assign code = instr[CODE_LSB +: CODE_SIZE];
  assign r_i  = instr[RI_LSB +: REG_SIZE];
  assign r_j  = instr[RJ_LSB +: REG_SIZE];
  assign r_k  = instr[RK_LSB +: REG_SIZE];
  assign imme = instr[IM_LSB +: IMME_SIZE];

  // Any bits below the immediate carry no meaning for this ISA.
  generate
    if (IM_LSB > 0) begin : g_low_bits
      logic unused_low_bits;
      assign unused_low_bits = ^instr[IM_LSB-1:0];
    end
  endgenerate

  // Immediate widening: sign- or zero-fill above the raw field, plain copy when widths match.
  generate
    if (DATA_SIZE > IMME_SIZE) begin : g_ext
      logic fill_bit;
      assign fill_bit = (SIGN_EXT != 0) ? imme[IMME_SIZE-1] : 1'b0;
      assign imme_ext = {{(DATA_SIZE-IMME_SIZE){fill_bit}}, imme};
    end else begin : g_copy
      assign imme_ext = imme;
    end
  endgenerate

  // Opcode classes; loads and stores compute an address, so their function is forced to ADD.
  always_comb begin
    flags  = classify_op(32'(code), 32'(LW_CODE), 32'(SW_CODE));
    i_func = imme;
    if (flags.is_load || flags.is_store) begin
      i_func = IMME_SIZE'(ADD_FUNC);
    end
  end

endmodule

// File: rtl/id_decode_stage.sv
// Instruction decode pipeline register with load-use bubble insertion, flush and hazard counting.
// Latency 1 cycle from input handshake to out_valid; 1 instr/cycle when no hazard.
// in_ready drops while a held entry is stalled by out_ready=0 or while a load-use bubble is inserted.
module id_decode_stage
  import id_decode_stage_pkg::*;
#(
  parameter int INSTR_SIZE = INSTR_SIZE_DEF,
  parameter int CODE_SIZE  = CODE_SIZE_DEF,
  parameter int REG_SIZE   = REG_SIZE_DEF,
  parameter int IMME_SIZE  = IMME_SIZE_DEF,
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int SIGN_EXT   = SIGN_EXT_DEF,
  parameter int LW_CODE    = LW_CODE_DEF,
  parameter int SW_CODE    = SW_CODE_DEF,
  parameter int ADD_FUNC   = ADD_FUNC_DEF,
  parameter int HCNT_SIZE  = HCNT_SIZE_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_SIZE-1:0] instr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CODE_SIZE-1:0]  i_code,
  output logic [REG_SIZE-1:0]   r_i,
  output logic [REG_SIZE-1:0]   r_j,
  output logic [REG_SIZE-1:0]   r_k,
  output logic [IMME_SIZE-1:0]  imme,
  output logic [DATA_SIZE-1:0]  imme_ext,
  output logic [IMME_SIZE-1:0]  i_func,
  output logic                  is_load,
  output logic                  is_store,
  output logic                  hazard,
  output logic [HCNT_SIZE-1:0]  hazard_cnt
);

  // One decoded instruction as held in the pipeline register.
  typedef struct packed {
    logic [CODE_SIZE-1:0] code;
    logic [REG_SIZE-1:0]  r_i;
    logic [REG_SIZE-1:0]  r_j;
    logic [REG_SIZE-1:0]  r_k;
    logic [IMME_SIZE-1:0] imme;
    logic [DATA_SIZE-1:0] imme_ext;
    logic [IMME_SIZE-1:0] i_func;
    op_flags_t            flags;
  } dec_entry_t;

  dec_entry_t           dec_in;
  dec_entry_t           ent_q, ent_d;
  logic                 valid_q, valid_d;
  logic [HCNT_SIZE-1:0] hcnt_q, hcnt_d;
  logic                 accept;

  // The same decoder feeds both the hazard comparison and the register input.
  instr_field_decode #(
    .INSTR_SIZE (INSTR_SIZE),
    .CODE_SIZE  (CODE_SIZE),
    .REG_SIZE   (REG_SIZE),
    .IMME_SIZE  (IMME_SIZE),
    .DATA_SIZE  (DATA_SIZE),
    .SIGN_EXT   (SIGN_EXT),
    .LW_CODE    (LW_CODE),
    .SW_CODE    (SW_CODE),
    .ADD_FUNC   (ADD_FUNC)
  ) u_dec (
    .instr    (instr),
    .code     (dec_in.code),
    .r_i      (dec_in.r_i),
    .r_j      (dec_in.r_j),
    .r_k      (dec_in.r_k),
    .imme     (dec_in.imme),
    .imme_ext (dec_in.imme_ext),
    .i_func   (dec_in.i_func),
    .flags    (dec_in.flags)
  );

  // Load-use check: an incoming source matching a held load's destination; r_k is no source for loads, r0 never hazards.
  always_comb begin
    hazard = 1'b0;
    if (in_valid && valid_q && ent_q.flags.is_load && (ent_q.r_i != '0)) begin
      if (dec_in.r_j == ent_q.r_i) begin
        hazard = 1'b1;
      end
      if ((dec_in.r_k == ent_q.r_i) && !dec_in.flags.is_load) begin
        hazard = 1'b1;
      end
    end
  end

  assign in_ready = !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Next register state: flush beats capture, capture beats drain, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    ent_d   = ent_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      ent_d   = dec_in;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Hazard cycle counter, saturating at all-ones; a flushed cycle does not count.
  always_comb begin
    hcnt_d = hcnt_q;
    if (hazard && !flush && (hcnt_q != '1)) begin
      hcnt_d = hcnt_q + HCNT_SIZE'(1);
    end
  end

  // Pipeline register and counter; reset drops any held entry immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ent_q   <= '0;
      hcnt_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      hcnt_q  <= hcnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign i_code     = ent_q.code;
  assign r_i        = ent_q.r_i;
  assign r_j        = ent_q.r_j;
  assign r_k        = ent_q.r_k;
  assign imme       = ent_q.imme;
  assign imme_ext   = ent_q.imme_ext;
  assign i_func     = ent_q.i_func;
  assign is_load    = ent_q.flags.is_load;
  assign is_store   = ent_q.flags.is_store;
  assign hazard_cnt = hcnt_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Randomised and directed bench for id_decode_stage with a scoreboard and a cycle-level reference model.
// Expected entries are queued when the reference model accepts an instruction; a monitor pops them on each output transfer.
// out_ready is driven directed or random to exercise stalls and load-use bubbles.
module tb_id_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  i_code;
  logic [4:0]  r_i, r_j, r_k;
  logic [10:0] imme;
  logic [31:0] imme_ext;
  logic [10:0] i_func;
  logic        is_load, is_store;
  logic        hazard;
  logic [15:0] hazard_cnt;

  id_decode_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .i_code     (i_code),
    .r_i        (r_i),
    .r_j        (r_j),
    .r_k        (r_k),
    .imme       (imme),
    .imme_ext   (imme_ext),
    .i_func     (i_func),
    .is_load    (is_load),
    .is_store   (is_store),
    .hazard     (hazard),
    .hazard_cnt (hazard_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference view of one instruction, computed with plain arithmetic.
  typedef struct {
    int unsigned code, ri, rj, rk, im, ext, func;
    bit          ld, st;
  } ref_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  ref_t exp_q[$];
  ref_t held;
  bit   mdl_vld  = 0;
  bit   mdl_acc  = 0;
  int   mdl_cnt  = 0;
  bit   rand_rdy = 0;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    r.code = w >> 26;
    r.ri   = (w >> 21) % 32;
    r.rj   = (w >> 16) % 32;
    r.rk   = (w >> 11) % 32;
    r.im   = w % 2048;
    r.ext  = (r.im >= 1024) ? r.im + 32'hFFFF_F800 : r.im;
    r.ld   = (r.code == 2);
    r.st   = (r.code == 3);
    r.func = (r.ld || r.st) ? 1 : r.im;
    return r;
  endfunction

  function automatic logic [31:0] mk(input int unsigned c, ri, rj, rk, im);
    return (c << 26) | (ri << 21) | (rj << 16) | (rk << 11) | im;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: judges hazard/in_ready/out_valid/hazard_cnt each cycle and queues accepted instrs.
  initial begin
    ref_t inc;
    bit   hz, rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mdl_vld = 0;
        mdl_acc = 0;
        mdl_cnt = 0;
        exp_q.delete();
      end else begin
        inc = ref_decode(instr);
        hz  = in_valid && mdl_vld && held.ld && (held.ri != 0) &&
              ((inc.rj == held.ri) || ((inc.rk == held.ri) && !inc.ld));
        rdy = !hz && (!mdl_vld || out_ready);
        chk("hazard", 64'(hazard), 64'(hz));
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("out_valid", 64'(out_valid), 64'(mdl_vld));
        chk("hazard_cnt", 64'(hazard_cnt), 64'(mdl_cnt));
        mdl_acc = !flush && in_valid && rdy;
        if (hz && !flush && mdl_cnt != 65535) mdl_cnt++;
        if (flush) begin
          if (mdl_vld) void'(exp_q.pop_back());
          mdl_vld = 0;
        end else if (mdl_acc) begin
          exp_q.push_back(inc);
          held    = inc;
          mdl_vld = 1;
        end else if (mdl_vld && out_ready) begin
          mdl_vld = 0;
        end
      end
    end
  end

  // Monitor: every output transfer must match the oldest outstanding expected entry.
  initial begin
    ref_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL mon_unexpected got=code %0h exp=no entry", i_code);
        end else begin
          e = exp_q.pop_front();
          chk("mon_code", 64'(i_code), 64'(e.code));
          chk("mon_r_i", 64'(r_i), 64'(e.ri));
          chk("mon_r_j", 64'(r_j), 64'(e.rj));
          chk("mon_r_k", 64'(r_k), 64'(e.rk));
          chk("mon_imme", 64'(imme), 64'(e.im));
          chk("mon_imme_ext", 64'(imme_ext), 64'(e.ext));
          chk("mon_i_func", 64'(i_func), 64'(e.func));
          chk("mon_flags", 64'({is_load, is_store}), 64'({e.ld, e.st}));
        end
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one instr until the reference model accepts it; returns the number of refused cycles.
  task automatic send(input logic [31:0] w, output int waits);
    int n = 0;
    in_valid = 1'b1;
    instr    = w;
    @(posedge clk);
    while (!mdl_acc && n < 100) begin
      n++;
      @(posedge clk);
    end
    if (!mdl_acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout got=not accepted exp=accepted instr=%08h", w);
    end
    #1;
    in_valid = 1'b0;
    instr    = $urandom;
    waits    = n;
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    int unsigned opc;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    instr     = 32'h0;
    #23 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_fields", 64'({i_code, r_i, r_j, r_k, imme}), 64'd0);
    chk("rst_imme_ext", 64'(imme_ext), 64'd0);
    chk("rst_i_func", 64'(i_func), 64'd0);
    chk("rst_flags", 64'({is_load, is_store}), 64'd0);
    chk("rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Field split: LW with negative immediate
    send(32'h0885_0FFF, w);
    chk("ld_code", 64'(i_code), 64'd2);
    chk("ld_regs", 64'({r_i, r_j, r_k}), 64'({5'd4, 5'd5, 5'd1}));
    chk("ld_imme", 64'(imme), 64'h7FF);
    chk("ld_i_func", 64'(i_func), 64'd1);
    chk("ld_imme_ext", 64'(imme_ext), 64'hFFFF_FFFF);
    chk("ld_flags", 64'({is_load, is_store}), 64'b10);
    idle(1);
    // Non-memory opcode keeps its function field
    send(mk(4, 1, 2, 3, 5), w);
    chk("alu_i_func", 64'(i_func), 64'h005);
    chk("alu_imme_ext", 64'(imme_ext), 64'h0000_0005);
    chk("alu_flags", 64'({is_load, is_store}), 64'b00);
    idle(1);

    // Back-to-back independent instrs: accepted every cycle
    for (int i = 0; i < 4; i++) begin
      send(mk(5, 6 + i, 10 + i, 11 + i, i), w);
      chk("b2b_wait", 64'(w), 64'd0);
    end
    idle(2);
    chk("b2b_hazard_cnt", 64'(hazard_cnt), 64'd0);

    // Load-use via r_j: one hazard cycle, then bubble-cycle acceptance
    send(mk(2, 4, 7, 8, 0), w);
    send(mk(4, 9, 4, 10, 0), w);
    chk("lu_wait", 64'(w), 64'd1);
    idle(2);
    chk("lu_hazard_cnt", 64'(hazard_cnt), 64'd1);
    // Load to r0 never hazards
    send(mk(2, 0, 7, 8, 0), w);
    send(mk(4, 9, 0, 0, 0), w);
    chk("r0_wait", 64'(w), 64'd0);
    // LW after LW: r_k is not a source of a load
    send(mk(2, 6, 1, 1, 0), w);
    send(mk(2, 7, 1, 6, 0), w);
    chk("lwlw_rk_wait", 64'(w), 64'd0);
    idle(2);
    chk("r0_hazard_cnt", 64'(hazard_cnt), 64'd1);
    // Store depending through r_k does hazard
    send(mk(2, 6, 1, 1, 0), w);
    send(mk(3, 9, 1, 6, 0), w);
    chk("sw_rk_wait", 64'(w), 64'd1);
    idle(2);
    chk("sw_hazard_cnt", 64'(hazard_cnt), 64'd2);

    // Downstream stall for 3 cycles, then release with a queued instr
    out_ready = 1'b0;
    send(mk(7, 3, 1, 2, 9), w);
    in_valid = 1'b1;
    instr    = mk(8, 1, 2, 3, 4);
    repeat (3) begin
      @(negedge clk);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_entry", 64'({i_code, r_i, imme}), 64'({6'd7, 5'd3, 11'd9}));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("release_next", 64'({out_valid, i_code}), 64'({1'b1, 6'd8}));
    idle(2);

    // Flush with a held entry and a pending input
    out_ready = 1'b0;
    send(mk(9, 1, 1, 1, 1), w);
    in_valid = 1'b1;
    instr    = mk(10, 2, 2, 2, 2);
    flush    = 1'b1;
    @(negedge clk);
    chk("pre_flush_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    idle(1);
    chk("flush_no_capture", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    idle(1);

    // Random traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1:    opc = 2;
        2:       opc = 3;
        default: opc = $urandom_range(0, 63);
      endcase
      send(mk(opc, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 2047)), w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    send(mk(11, 5, 5, 5, 5), w);
    #2;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_fields", 64'({i_code, r_i}), 64'd0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("post_rst_hazard_cnt", 64'(hazard_cnt), 64'd0);
    send(mk(2, 5, 1, 1, 0), w);
    send(mk(4, 1, 5, 0, 0), w);
    chk("post_rst_lu_wait", 64'(w), 64'd1);
    idle(3);
    chk("post_rst_hazard_cnt1", 64'(hazard_cnt), 64'd1);
    chk("post_rst_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
